// File: rtl/board_detect_ctrl.sv
// Board detection controller: settles, samples the IO board-class flags until a
// stable code is seen, then locks or faults. Optional rescan via BOARD_DETECT_RESCAN_EN.
module board_detect_ctrl #(
  parameter int SETTLE_CYCLES  = 1024,
  parameter int STABLE_COUNT   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       is_none,
  input  logic       is_qla,
  input  logic       is_dqla,
  input  logic       is_drac,
  input  logic       rescan,
  output logic [2:0] board_type,
  output logic       valid,
  output logic       busy,
  output logic       fault,
  output logic [3:0] retries
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_LOCKED, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] stable_q, stable_d, stable_inc;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [2:0]    prev_q, prev_d;
  logic [2:0]    type_q, type_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [3:0]    retries_q, retries_d;
  logic [2:0]    code;
  logic          rescan_go;
  logic          scan_start;

`ifdef BOARD_DETECT_RESCAN_EN
  assign rescan_go = rescan;
`else
  logic rescan_unused;
  assign rescan_unused = rescan;
  assign rescan_go     = 1'b0;
`endif

  always_comb begin
    unique case ({is_drac, is_dqla, is_qla, is_none})
      4'b0000: code = 3'd0;
      4'b0001: code = 3'd1;
      4'b0010: code = 3'd2;
      4'b0100: code = 3'd3;
      4'b1000: code = 3'd4;
      default: code = 3'd7;
    endcase
  end

  // Both counters saturate so they can never wrap into a false match.
  assign stable_inc = (stable_q == CW'(STABLE_COUNT)) ? stable_q : stable_q + CW'(1);
  assign tmo_inc    = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    stable_d   = stable_q;
    tmo_d      = tmo_q;
    prev_d     = prev_q;
    type_d     = type_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    retries_d  = retries_q;
    scan_start = 1'b0;
    unique case (state_q)
      S_IDLE: scan_start = 1'b1;
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_SAMPLE;
        else                settle_d = settle_q - SW'(1);
      end
      S_SAMPLE: begin
        stable_d = (code == prev_q) ? stable_inc : CW'(1);
        prev_d   = code;
        tmo_d    = tmo_inc;
        // A completed run outranks a timeout landing on the same cycle.
        if (stable_d == CW'(STABLE_COUNT)) begin
          type_d = code;
          if (code != 3'd0 && code != 3'd7) begin
            state_d = S_LOCKED;
            valid_d = 1'b1;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end else if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
          state_d   = S_FAULT;
          type_d    = 3'd0;
          fault_d   = 1'b1;
          retries_d = (retries_q == 4'd15) ? retries_q : retries_q + 4'd1;
        end
      end
      S_LOCKED, S_FAULT: scan_start = rescan_go;
      default: state_d = S_IDLE;
    endcase
    if (scan_start) begin
      state_d  = S_SETTLE;
      settle_d = SW'(SETTLE_CYCLES - 1);
      stable_d = '0;
      tmo_d    = '0;
      prev_d   = 3'd0;
      type_d   = 3'd0;
      valid_d  = 1'b0;
      fault_d  = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      stable_q  <= '0;
      tmo_q     <= '0;
      prev_q    <= 3'd0;
      type_q    <= 3'd0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      retries_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      stable_q  <= stable_d;
      tmo_q     <= tmo_d;
      prev_q    <= prev_d;
      type_q    <= type_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      retries_q <= retries_d;
    end
  end

  assign board_type = type_q;
  assign valid      = valid_q;
  assign fault      = fault_q;
  assign retries    = retries_q;
  assign busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);

endmodule

// File: doc/board_detect_ctrl.md
BOARD_DETECT_CTRL -- requirements
Module: board_detect_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1024: sysclk cycles to wait after scan start before the first sample.
REQ-002 Parameter STABLE_COUNT, default 16: consecutive identical samples required to lock.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: SAMPLE-state cycles allowed before FAULT.
REQ-004 sysclk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 is_none, is_qla, is_dqla, is_drac  input  1 each  raw board-classification flags from the IO pull-up decode.
REQ-007 rescan  input  1  single-cycle request to restart detection.
REQ-008 board_type  output  3  latched code: 0 unknown, 1 NONE, 2 QLA, 3 DQLA, 4 DRAC, 7 conflict.
REQ-009 valid  output  1  board_type locked and trustworthy.
REQ-010 busy  output  1  high in SETTLE or SAMPLE.
REQ-011 fault  output  1  timeout or locked conflict.
REQ-012 retries  output  4  saturating count of timeouts since reset.

Function
REQ-013 Each cycle the flags are encoded to a sample code: exactly one flag high -> its code (1-4); none high -> 0; two or more high -> 7.
REQ-014 States: IDLE, SETTLE, SAMPLE, LOCKED, FAULT.
REQ-015 IDLE moves to SETTLE on the cycle after reset deasserts, with no rescan needed.
REQ-016 SETTLE loads a down-counter with SETTLE_CYCLES-1 on entry and moves to SAMPLE the cycle after it reaches 0.
REQ-017 In SAMPLE each cycle: if the code equals the stored previous code, the stable counter increments; otherwise it resets to 1 and the previous code is updated.
REQ-018 When the stable counter reaches STABLE_COUNT with code 1-4: latch board_type and go to LOCKED; valid rises on the next cycle.
REQ-019 When the stable counter reaches STABLE_COUNT with code 0 or 7: latch board_type and go to FAULT; valid stays 0.
REQ-020 Timeout counter reaching TIMEOUT_CYCLES in SAMPLE -> FAULT with board_type=0; retries increments and saturates at 15.
REQ-021 Lock or fault and timeout in the same cycle: lock or fault wins; retries is not incremented.
REQ-022 On scan start, board_type, valid and fault clear; busy is 1 exactly while in SETTLE or SAMPLE.
REQ-023 rescan while busy is ignored.
REQ-024 Counters are sized by $clog2 of their parameter and never wrap: the stable counter holds at STABLE_COUNT.
REQ-025 Flag changes after LOCKED do not alter outputs.

Reset
REQ-026 reset forces IDLE, board_type=0, valid=0, busy=0, fault=0, retries=0, and clears all counters and the stored previous code.
REQ-027 reset asserted mid-scan aborts the scan; detection restarts from SETTLE after reset deasserts.

Configuration
REQ-028 Macro BOARD_DETECT_RESCAN_EN, when defined: rescan in LOCKED or FAULT goes to SETTLE on the next cycle (REQ-022 applies).
REQ-029 Without BOARD_DETECT_RESCAN_EN: rescan is ignored; LOCKED and FAULT are left only by reset.

Verification
REQ-030 is_qla=1 steady from reset, SETTLE_CYCLES=8, STABLE_COUNT=4 -> busy for 12 cycles; board_type=2; valid=1 on cycle 13 after reset release.
REQ-031 is_dqla toggles every 3 cycles for 40 cycles, then holds 1 -> no lock during toggling; lock at board_type=3 exactly 4 samples after it holds.
REQ-032 is_qla=is_drac=1 steady -> board_type=7, fault=1, valid=0.
REQ-033 Flags alternate every cycle with TIMEOUT_CYCLES=20 -> fault=1, board_type=0, retries=1; repeated via rescan (RESCAN_EN defined) 16 times -> retries stays 15.
REQ-034 reset pulsed mid-SAMPLE, then is_none=1 -> outputs cleared during reset; rescan completes with board_type=1.
REQ-035 With RESCAN_EN undefined, rescan pulsed in LOCKED -> board_type and valid unchanged; with it defined -> valid drops the next cycle and busy=1.
